// File: rtl/sa_sequencer_pkg.sv
// Shared constants and FSM state encoding for the systolic-array sequencer.
package sa_sequencer_pkg;

  localparam int DEF_BITWIDTH = 4;
  localparam int DEF_OUTWIDTH = 2 * DEF_BITWIDTH;
  localparam int NUM_ELEM     = 16;
  localparam int NUM_GROUPS   = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_COLLECT  = 3'd1;
  localparam state_t ST_BURST_W  = 3'd2;
  localparam state_t ST_BURST_I  = 3'd3;
  localparam state_t ST_WAIT_CMP = 3'd4;
  localparam state_t ST_STORE    = 3'd5;
  localparam state_t ST_DRAIN    = 3'd6;

endpackage

// File: rtl/sa_sequencer_if.sv
// Host-side element and result streams of the sequencer.
interface sa_sequencer_if
  import sa_sequencer_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int OUTWIDTH = DEF_OUTWIDTH
);
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUTWIDTH-1:0] out_data;
  logic                out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sa_result_buf.sv
// Result register file: one write port, one combinational read port.
module sa_result_buf #(
  parameter int OUTWIDTH = 8,
  parameter int DEPTH    = 16,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [OUTWIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [OUTWIDTH-1:0] rd_data
);

  logic [OUTWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sa_sequencer.sv
// Collects 16 weights + 16 inputs, bursts them into the array, gathers the
// 16 results and streams them back to the host.
module sa_sequencer
  import sa_sequencer_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int OUTWIDTH = 2 * BITWIDTH,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  sa_sequencer_if.slave       host,
  output logic                busy,
  output logic                timeout_err,
  output logic [BITWIDTH-1:0] sa_data_in,
  output logic                sa_load_weights,
  output logic                sa_load_inputs,
  output logic                sa_store_outputs,
  input  logic [OUTWIDTH-1:0] sa_results,
  input  logic                sa_valid_out
);

  localparam int BUF_DEPTH  = NUM_ELEM * NUM_GROUPS;
  localparam int IDX_W      = $clog2(BUF_DEPTH);
  localparam int EIDX_W     = $clog2(NUM_ELEM);
  localparam int CNT_W      = (TIMEOUT > 32) ? $clog2(TIMEOUT) : 6;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    wr_idx, wr_idx_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [EIDX_W-1:0]   drain_idx, drain_nxt;
  logic                in_ready_r, in_ready_nxt;
  logic                busy_r, busy_nxt;
  logic                terr_r, terr_nxt;
  logic                ldw_r, ldw_nxt;
  logic                ldi_r, ldi_nxt;
  logic                st_r, st_nxt;
  logic [BITWIDTH-1:0] sa_data_r, sa_data_nxt;
  logic                out_valid_r, out_valid_nxt;
  logic                out_last_r, out_last_nxt;
  logic [OUTWIDTH-1:0] out_data_r;

  logic [BITWIDTH-1:0] elem_buf [BUF_DEPTH];
  logic                buf_we, res_we, out_load, accept;
  logic [EIDX_W-1:0]   res_widx, rd_idx;
  logic [OUTWIDTH-1:0] rd_data;

  assign accept   = host.in_valid && in_ready_r;
  // Slot k is captured at the end of store cycle k+1; cnt=16 wraps to slot 15.
  assign res_widx = cnt[EIDX_W-1:0] - EIDX_W'(1);
  assign rd_idx   = (state == ST_DRAIN) ? drain_idx + EIDX_W'(1) : '0;

  always_comb begin
    state_nxt     = state;
    wr_idx_nxt    = wr_idx;
    cnt_nxt       = cnt;
    drain_nxt     = drain_idx;
    in_ready_nxt  = in_ready_r;
    busy_nxt      = busy_r;
    terr_nxt      = terr_r;
    ldw_nxt       = ldw_r;
    ldi_nxt       = ldi_r;
    st_nxt        = st_r;
    sa_data_nxt   = sa_data_r;
    out_valid_nxt = out_valid_r;
    out_last_nxt  = out_last_r;
    buf_we        = 1'b0;
    res_we        = 1'b0;
    out_load      = 1'b0;

    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          buf_we     = 1'b1;
          wr_idx_nxt = wr_idx + IDX_W'(1);
          terr_nxt   = 1'b0;
          busy_nxt   = 1'b1;
          state_nxt  = ST_COLLECT;
          if (wr_idx == IDX_W'(BUF_DEPTH - 1)) begin
            state_nxt    = ST_BURST_W;
            wr_idx_nxt   = '0;
            in_ready_nxt = 1'b0;
            ldw_nxt      = 1'b1;
            sa_data_nxt  = elem_buf[0];
            cnt_nxt      = '0;
          end
        end
      end

      // Data for cycle k+1 is fetched at the end of cycle k so the array
      // sees one element per cycle with no bubble between the two bursts.
      ST_BURST_W: begin
        if (cnt == CNT_W'(NUM_ELEM - 1)) begin
          state_nxt   = ST_BURST_I;
          ldw_nxt     = 1'b0;
          ldi_nxt     = 1'b1;
          sa_data_nxt = elem_buf[NUM_ELEM];
          cnt_nxt     = '0;
        end else begin
          sa_data_nxt = elem_buf[{1'b0, cnt[EIDX_W-1:0] + EIDX_W'(1)}];
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end

      ST_BURST_I: begin
        if (cnt == CNT_W'(NUM_ELEM - 1)) begin
          state_nxt   = ST_WAIT_CMP;
          ldi_nxt     = 1'b0;
          sa_data_nxt = '0;
          cnt_nxt     = '0;
        end else begin
          sa_data_nxt = elem_buf[{1'b1, cnt[EIDX_W-1:0] + EIDX_W'(1)}];
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end

      ST_WAIT_CMP: begin
        if (sa_valid_out) begin
          state_nxt = ST_STORE;
          st_nxt    = 1'b1;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt    = ST_IDLE;
          terr_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          in_ready_nxt = 1'b1;
          cnt_nxt      = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_STORE: begin
        res_we = (cnt != '0);
        if (cnt == CNT_W'(NUM_ELEM - 1)) st_nxt = 1'b0;
        if (cnt == CNT_W'(NUM_ELEM)) begin
          state_nxt     = ST_DRAIN;
          out_valid_nxt = 1'b1;
          out_last_nxt  = 1'b0;
          out_load      = 1'b1;
          drain_nxt     = '0;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_DRAIN: begin
        if (host.out_ready) begin
          if (drain_idx == EIDX_W'(NUM_ELEM - 1)) begin
            state_nxt     = ST_IDLE;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            busy_nxt      = 1'b0;
            in_ready_nxt  = 1'b1;
            drain_nxt     = '0;
          end else begin
            drain_nxt    = drain_idx + EIDX_W'(1);
            out_load     = 1'b1;
            out_last_nxt = (drain_idx + EIDX_W'(1)) == EIDX_W'(NUM_ELEM - 1);
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wr_idx      <= '0;
      cnt         <= '0;
      drain_idx   <= '0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      terr_r      <= 1'b0;
      ldw_r       <= 1'b0;
      ldi_r       <= 1'b0;
      st_r        <= 1'b0;
      sa_data_r   <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_idx      <= wr_idx_nxt;
      cnt         <= cnt_nxt;
      drain_idx   <= drain_nxt;
      in_ready_r  <= in_ready_nxt;
      busy_r      <= busy_nxt;
      terr_r      <= terr_nxt;
      ldw_r       <= ldw_nxt;
      ldi_r       <= ldi_nxt;
      st_r        <= st_nxt;
      sa_data_r   <= sa_data_nxt;
      out_valid_r <= out_valid_nxt;
      out_last_r  <= out_last_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) elem_buf[wr_idx] <= host.in_data;
    if (out_load) out_data_r <= rd_data;
  end

  sa_result_buf #(
    .OUTWIDTH (OUTWIDTH),
    .DEPTH    (NUM_ELEM),
    .IDX_W    (EIDX_W)
  ) u_result_buf (
    .clk     (clk),
    .wr_en   (res_we),
    .wr_idx  (res_widx),
    .wr_data (sa_results),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign host.in_ready    = in_ready_r;
  assign host.out_valid   = out_valid_r;
  assign host.out_last    = out_last_r;
  assign host.out_data    = out_data_r;
  assign busy             = busy_r;
  assign timeout_err      = terr_r;
  assign sa_data_in       = sa_data_r;
  assign sa_load_weights  = ldw_r;
  assign sa_load_inputs   = ldi_r;
  assign sa_store_outputs = st_r;

endmodule

// File: tb/tb_sa_sequencer.sv
// Scoreboard bench for sa_sequencer with a behavioural systolic-array model.
module tb_sa_sequencer;

  localparam int BW = 4;
  localparam int OW = 8;
  localparam int TO = 64;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          busy, timeout_err;
  logic [BW-1:0] sa_data_in;
  logic          ldw, ldi, st;
  logic [OW-1:0] sa_results;
  logic          sa_valid_out;

  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  logic [BW-1:0] exp_burst [$];
  exp_t          oq [$];

  bit            pulse_en, stray_en, toggle_rdy;
  logic [OW-1:0] res_base;
  int            wc, sc;
  logic          prev_li;

  logic [BW-1:0] va [32];
  int            cyc, cnt_li, nb;

  always #5 clk = ~clk;

  sa_sequencer_if #(.BITWIDTH(BW), .OUTWIDTH(OW)) hif ();

  sa_sequencer #(.BITWIDTH(BW), .OUTWIDTH(OW), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .host             (hif),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .sa_data_in       (sa_data_in),
    .sa_load_weights  (ldw),
    .sa_load_inputs   (ldi),
    .sa_store_outputs (st),
    .sa_results       (sa_results),
    .sa_valid_out     (sa_valid_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},    32'(hif.in_ready), 1);
    chk({tag, "_out_valid"},   32'(hif.out_valid), 0);
    chk({tag, "_out_last"},    32'(hif.out_last), 0);
    chk({tag, "_busy"},        32'(busy), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_sa_data_in"},  32'(sa_data_in), 0);
    chk({tag, "_ld_weights"},  32'(ldw), 0);
    chk({tag, "_ld_inputs"},   32'(ldi), 0);
    chk({tag, "_store"},       32'(st), 0);
  endtask

  // Array model: completion pulse 10 cycles after the input burst, results in S(k+1).
  initial begin
    sa_valid_out = 1'b0;
    sa_results   = 8'hEE;
    prev_li      = 1'b0;
    wc           = -1;
    sc           = -1;
    forever begin
      @(posedge clk); #1;
      sa_valid_out = 1'b0;
      if (!reset_n) begin
        prev_li = 1'b0; wc = -1; sc = -1; sa_results = 8'hEE;
      end else begin
        if (prev_li && !ldi) wc = 0;
        else if (wc >= 0) wc++;
        if (wc == 10) begin
          if (pulse_en) sa_valid_out = 1'b1;
          wc = -1;
        end
        if (stray_en && ldw) sa_valid_out = 1'b1;
        if (sc < 0 && st) sc = 0;
        else if (sc >= 0) sc++;
        if (sc > 16) sc = -1;
        sa_results = (sc >= 1) ? res_base + 8'(sc - 1) : 8'hEE;
        prev_li = ldi;
      end
    end
  end

  initial begin
    hif.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      hif.out_ready = toggle_rdy ? ~hif.out_ready : 1'b1;
    end
  end

  // Burst monitor: 16 weight cycles then 16 input cycles, contiguous, data in order.
  initial begin
    int rl;
    rl = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) rl = 0;
      else if (ldw || ldi) begin
        chk("ld_weights_phase", 32'(ldw), 32'(rl < 16));
        chk("ld_inputs_phase",  32'(ldi), 32'(rl >= 16));
        chk("in_ready_in_burst", 32'(hif.in_ready), 0);
        if (exp_burst.size() == 0) note_fail("burst_unexpected");
        else chk("sa_data_in", 32'(sa_data_in), 32'(exp_burst.pop_front()));
        rl++;
      end else if (rl != 0) begin
        chk("burst_len", 32'(rl), 32);
        rl = 0;
      end
    end
  end

  // Output monitor: compare against queue head, pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && hif.out_valid) begin
        if (oq.size() == 0) note_fail("out_unexpected");
        else begin
          chk("out_data", 32'(hif.out_data), 32'(oq[0].d));
          chk("out_last", 32'(hif.out_last), 32'(oq[0].l));
          if (hif.out_ready) begin
            void'(oq.pop_front());
            xfers++;
          end
        end
      end
    end
  end

  task automatic send_all(input logic [BW-1:0] v [32], input bit gaps, input bit hold);
    bit acc;
    int n;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      exp_burst.push_back(v[i]);
      hif.in_valid = 1'b1;
      hif.in_data  = v[i];
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 100) begin
        @(negedge clk); acc = hif.in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) begin
        note_fail("accept_wait");
        break;
      end
      if (i == 0) begin
        chk("terr_after_accept", 32'(timeout_err), 0);
        chk("busy_after_accept", 32'(busy), 1);
      end
      if (!(hold && i == 31)) hif.in_valid = 1'b0;
    end
    if (hold) hif.in_data = 4'hA;
  endtask

  task automatic hold_until_last();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      chk("in_ready_held_valid", 32'(hif.in_ready), 0);
      if (hif.out_valid && hif.out_last && hif.out_ready) done = 1'b1;
    end
    if (!done) note_fail("hold_last_wait");
    @(posedge clk); #1;
    hif.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < bound);
    if (busy) note_fail("idle_wait");
  endtask

  task automatic run_full(input logic [BW-1:0] v [32], input bit gaps, input bit hold,
                          input logic [OW-1:0] base, input bit tog);
    exp_t e;
    res_base   = base;
    toggle_rdy = tog;
    for (int k = 0; k < 16; k++) begin
      e.d = base + 8'(k);
      e.l = (k == 15);
      oq.push_back(e);
    end
    send_all(v, gaps, hold);
    if (hold) hold_until_last();
    wait_idle(600);
    chk("transfer_count", 32'(xfers), 16);
    chk("out_queue_empty", 32'(oq.size()), 0);
    chk("burst_queue_empty", 32'(exp_burst.size()), 0);
    chk("idle_in_ready", 32'(hif.in_ready), 1);
    chk("idle_out_valid", 32'(hif.out_valid), 0);
    xfers = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    hif.in_valid = 1'b0;
    hif.in_data  = '0;
    pulse_en     = 1'b1;
    stray_en     = 1'b0;
    toggle_rdy   = 1'b0;
    res_base     = 8'h10;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst");

    // Ascending weights, descending inputs, random gaps, stalling consumer.
    for (int i = 0; i < 32; i++) va[i] = (i < 16) ? 4'(i) : 4'(31 - i);
    run_full(va, 1'b1, 1'b0, 8'h10, 1'b1);

    // Mixed pattern, back-to-back, in_valid held through busy, stray completion pulses.
    for (int i = 0; i < 32; i++) va[i] = 4'(i * 7 + 3);
    stray_en = 1'b1;
    run_full(va, 1'b0, 1'b1, 8'hA0, 1'b0);
    stray_en = 1'b0;

    // Array never completes.
    pulse_en = 1'b0;
    for (int i = 0; i < 32; i++) va[i] = ~4'(i);
    send_all(va, 1'b0, 1'b0);
    nb = 0;
    while (!ldi && nb < 100) begin @(negedge clk); nb++; end
    while (ldi && nb < 200) begin @(negedge clk); nb++; end
    if (nb >= 200) note_fail("burst_wait");
    cyc = 0;
    while (!timeout_err && cyc < 200) begin @(negedge clk); cyc++; end
    chk("timeout_cycles", 32'(cyc), TO);
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_in_ready", 32'(hif.in_ready), 1);
    chk("timeout_out_valid", 32'(hif.out_valid), 0);
    repeat (5) @(negedge clk);
    chk("timeout_sticky", 32'(timeout_err), 1);
    pulse_en = 1'b1;
    for (int i = 0; i < 32; i++) va[i] = 4'(i) ^ 4'h9;
    run_full(va, 1'b1, 1'b0, 8'h30, 1'b0);

    // Reset asserted in input-burst cycle 5.
    for (int i = 0; i < 32; i++) va[i] = 4'(i);
    send_all(va, 1'b0, 1'b0);
    cnt_li = 0;
    nb     = 0;
    while (cnt_li < 6 && nb < 200) begin
      @(negedge clk);
      if (ldi) cnt_li++;
      nb++;
    end
    if (cnt_li < 6) note_fail("reset_point_wait");
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_burst.delete();
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 32; i++) va[i] = 4'(i * 5);
    run_full(va, 1'b1, 1'b0, 8'h50, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
